led_scan_ctrl: RTL and testbench
================================

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 16: column data width.
REQ-002 The block SHALL have parameter DWELL, default 1000: lit cycles per row, legal range 1 or more.
REQ-003 The block SHALL have parameter BLANK, default 4: dark cycles before each row, legal range 1 or more.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port en, input, 1: scan enable.
REQ-007 Port wr_en, input, 1: write strobe to the back bank.
REQ-008 Port wr_addr, input, 5: row address for a write.
REQ-009 Port wr_data, input, DW: column pattern for a write.
REQ-010 Port swap_req, input, 1: request to exchange the front and back banks.
REQ-011 Port swap_ack, output, 1: one-cycle pulse when a bank swap takes effect.
REQ-012 Port row_idx, output, 5: binary row index that drives the 5-to-32 row decoder.
REQ-013 Port row_on, output, 1: row driver enable; 0 means all rows are dark.
REQ-014 Port col_data, output, DW: column pattern for the current row.
REQ-015 Port frame_done, output, 1: one-cycle pulse at each frame wrap.

Function
REQ-016 Storage SHALL be two banks, each 32 x DW registers; one bank is front (displayed) and the other is back (host-writable).
REQ-017 A write (wr_en=1) SHALL store wr_data into back[wr_addr] at the clock edge.
- The front bank SHALL never be writable.
- A write in the same cycle as a swap SHALL land in the bank that was back before that edge.
REQ-018 The FSM SHALL have exactly three states: IDLE, BLANK and ON.
REQ-019 Transitions in IDLE: if en=1, the next state SHALL be BLANK with row_idx=0 and col_data=front[0]; otherwise the FSM stays in IDLE.
REQ-020 BLANK SHALL hold row_on=0 for exactly BLANK cycles and then go to ON.
REQ-021 ON SHALL hold row_on=1 for exactly DWELL cycles and then go to BLANK.
- On that edge, row_idx SHALL increment modulo 32 (31 wraps to 0).
- On that edge, col_data SHALL load front[new row_idx].
REQ-022 row_idx and col_data SHALL change only on edges where row_on is, or becomes, 0; they SHALL never change while row_on=1.
REQ-023 The row period SHALL be BLANK+DWELL cycles and the frame period SHALL be 32*(BLANK+DWELL) cycles, with no extra gap cycles.
REQ-024 On the edge that ends ON for row 31, frame_done SHALL be 1 for the next cycle only.
REQ-025 swap_req SHALL set a single pending flag.
- Further requests while the flag is pending SHALL be merged into it.
- The effective request SHALL be (pending OR swap_req).
REQ-026 While scanning, a swap SHALL occur only on the row-31-to-row-0 edge.
- On that edge, front and back SHALL toggle and pending SHALL clear.
- swap_ack SHALL pulse in the same cycle as frame_done.
- col_data for row 0 SHALL come from the new front bank.
REQ-027 In IDLE, an effective swap request SHALL swap on the next edge, with swap_ack pulsing for 1 cycle.
REQ-028 If en=0 while in BLANK or ON, the next state SHALL be IDLE.
- On that edge: row_on=0, row_idx=0, col_data=0, and no frame_done.
- The pending flag SHALL be retained.
REQ-029 en=1 together with a pending swap in IDLE SHALL swap first, so that row 0 shows the new front bank.
REQ-030 The dwell/blank counter SHALL be wide enough for max(DWELL,BLANK) and SHALL reload on every state entry.

Reset
REQ-031 On rst=1, all outputs SHALL immediately go to these values: row_idx=0, row_on=0, col_data=0, swap_ack=0, frame_done=0.
REQ-032 On rst=1, the FSM SHALL go to IDLE, front SHALL be bank 0, pending SHALL clear, the counter SHALL clear, and both banks SHALL clear to 0.
REQ-033 Reset arriving mid-row or mid-swap SHALL abort the operation with no partial swap; the first edge after rst falls SHALL follow the IDLE rules.

Verification (bench parameters: DWELL=3, BLANK=2, DW=16)
REQ-034 Scan timing: en=1 after reset -> row_idx=0 with row_on 0,0,1,1,1, then row_idx=1 with the same pattern; period 5 cycles; frame_done after 160 cycles.
REQ-035 Wrap: end of ON for row 31 -> row_idx=0, row_on=0, frame_done=1 for exactly 1 cycle.
REQ-036 Double buffer: write back[5]=0xA5A5 and pulse swap_req during row 10 -> row 5 shows 0x0000 for the rest of the frame; swap_ack coincides with frame_done; next frame row 5 shows 0xA5A5.
REQ-037 Disable: drop en during the 2nd ON cycle of row 7 -> next cycle row_on=0, row_idx=0, col_data=0; re-enable -> scan restarts at row 0 with BLANK.
REQ-038 Swap in IDLE: en=0, swap_req pulse -> swap_ack=1 exactly one cycle later; a second swap_req pulse toggles the front bank back.
REQ-039 Async reset: assert rst between clock edges while row_on=1 and swap is pending -> outputs go to 0 before the next edge; after release, no swap_ack occurs.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// LED matrix row scanner with a double-buffered 32-row frame store.
// Rows are blanked before each lit period; bank swaps land on frame wrap.
module led_scan_ctrl #(
    parameter int DW    = 16,
    parameter int DWELL = 1000,
    parameter int BLANK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          wr_en,
    input  logic [4:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic [4:0]    row_idx,
    output logic          row_on,
    output logic [DW-1:0] col_data,
    output logic          frame_done
);

    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ON
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          front;
    logic          pending;
    logic [DW-1:0] bank [2][32];

    logic          cnt_done;
    logic          eff_req;
    logic          wrap;
    logic          swap_now;
    logic          front_nxt;
    logic [4:0]    row_nxt;

    assign cnt_done  = (cnt == '0);
    assign eff_req   = pending | swap_req;
    assign wrap      = (state == S_ON) && cnt_done && en && (row_idx == 5'd31);
    assign swap_now  = (state == S_IDLE) ? eff_req : (wrap & eff_req);
    assign front_nxt = front ^ swap_now;
    assign row_nxt   = row_idx + 5'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: en low always drops back to IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  state_nxt = en ? S_BLANK : S_IDLE;
            S_BLANK: state_nxt = !en ? S_IDLE : (cnt_done ? S_ON : S_BLANK);
            S_ON:    state_nxt = !en ? S_IDLE : (cnt_done ? S_BLANK : S_ON);
            default: state_nxt = S_IDLE;
        endcase
    end

    // Row driver is lit only in ON
    always_comb begin
        row_on = (state == S_ON);
    end

    // Phase counter reloads whenever a new state is entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= (state_nxt == S_ON) ? CW'(DWELL - 1) : CW'(BLANK - 1);
        end else if (!cnt_done) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Row/column registers change only while the row is dark
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx  <= '0;
            col_data <= '0;
        end else if (state_nxt == S_IDLE) begin
            row_idx  <= '0;
            col_data <= '0;
        end else if (state == S_IDLE) begin
            row_idx  <= '0;
            col_data <= bank[front_nxt][0];
        end else if (state == S_ON && state_nxt == S_BLANK) begin
            row_idx  <= row_nxt;
            col_data <= bank[front_nxt][row_nxt];
        end
    end

    // Swap bookkeeping and one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front      <= 1'b0;
            pending    <= 1'b0;
            swap_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            front      <= front_nxt;
            pending    <= swap_now ? 1'b0 : eff_req;
            swap_ack   <= swap_now;
            frame_done <= wrap;
        end
    end

    // Host writes always target the bank that is back before this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < 32; a++) begin
                    bank[b][a] <= '0;
                end
            end
        end else if (wr_en) begin
            bank[~front][wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Testbench for led_scan_ctrl: vector table, corner-case sequences,
// and randomized traffic against a phase-arithmetic reference model.
module tb_led_scan_ctrl;

    localparam int DW    = 16;
    localparam int DWELL = 3;
    localparam int BLANK = 2;
    localparam int RP    = BLANK + DWELL;
    localparam int FRAME = 32 * RP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          wr_en = 1'b0;
    logic [4:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          swap_req = 1'b0;
    logic          swap_ack;
    logic [4:0]    row_idx;
    logic          row_on;
    logic [DW-1:0] col_data;
    logic          frame_done;

    int checks = 0;
    int failures = 0;
    bit mon = 1'b0;

    led_scan_ctrl #(.DW(DW), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .row_idx(row_idx), .row_on(row_on), .col_data(col_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: position in the frame is a plain cycle count p
    logic [DW-1:0] mb [2][32];
    int            p;
    bit            scan, mfront, mpend, eff, sw, ob;
    logic [4:0]    m_row;
    logic          m_on, m_fd, m_ack;
    logic [DW-1:0] m_col;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 32; a++) mb[b][a] = '0;
            p = 0; scan = 0; mfront = 0; mpend = 0;
            m_row = 0; m_on = 0; m_col = 0; m_fd = 0; m_ack = 0;
        end else begin
            ob = !mfront;
            eff = mpend | swap_req;
            sw = 0;
            m_fd = 0;
            if (!scan) begin
                sw = eff;
                if (sw) mfront = !mfront;
                m_row = 0; m_on = 0; m_col = 0;
                if (en) begin
                    scan = 1; p = 0;
                    m_col = mb[mfront][0];
                end
            end else if (!en) begin
                scan = 0;
                m_row = 0; m_on = 0; m_col = 0;
            end else begin
                p = p + 1;
                if (p == FRAME) begin
                    p = 0; m_fd = 1; sw = eff;
                    if (sw) mfront = !mfront;
                end
                m_row = 5'((p / RP) % 32);
                m_on = (p % RP) >= BLANK;
                if (p % RP == 0) m_col = mb[mfront][m_row];
            end
            m_ack = sw;
            mpend = sw ? 1'b0 : eff;
            if (wr_en) mb[ob][wr_addr] = wr_data;
        end
    end

    // Continuous comparison against the model
    always @(negedge clk) begin
        if (mon) begin
            checks++;
            if ({row_idx, row_on, col_data, frame_done, swap_ack} !==
                {m_row, m_on, m_col, m_fd, m_ack}) begin
                failures++;
                $display("FAIL model t=%0t got row=%0d on=%b col=%h fd=%b ack=%b want row=%0d on=%b col=%h fd=%b ack=%b",
                         $time, row_idx, row_on, col_data, frame_done, swap_ack,
                         m_row, m_on, m_col, m_fd, m_ack);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        en = 0; wr_en = 0; swap_req = 0;
        cyc(); cyc();
        #2 rst = 1'b0;
        cyc();
    endtask

    typedef struct {
        logic          en;
        logic          wr;
        logic [4:0]    addr;
        logic [DW-1:0] data;
        logic          swap;
        logic [4:0]    row;
        logic          on;
        logic [DW-1:0] col;
        logic          fd;
        logic          ack;
    } vec_t;

    vec_t tbl [12];
    int   n;
    int   acks;

    initial begin
        tbl[0]  = '{0, 0, 5'd0, 16'h0000, 1, 5'd0, 0, 16'h0000, 0, 1};
        tbl[1]  = '{0, 0, 5'd0, 16'h0000, 0, 5'd0, 0, 16'h0000, 0, 0};
        tbl[2]  = '{0, 1, 5'd0, 16'h1234, 0, 5'd0, 0, 16'h0000, 0, 0};
        tbl[3]  = '{0, 0, 5'd0, 16'h0000, 1, 5'd0, 0, 16'h0000, 0, 1};
        tbl[4]  = '{1, 0, 5'd0, 16'h0000, 0, 5'd0, 0, 16'h1234, 0, 0};
        tbl[5]  = '{1, 0, 5'd0, 16'h0000, 0, 5'd0, 0, 16'h1234, 0, 0};
        tbl[6]  = '{1, 0, 5'd0, 16'h0000, 0, 5'd0, 1, 16'h1234, 0, 0};
        tbl[7]  = '{1, 0, 5'd0, 16'h0000, 0, 5'd0, 1, 16'h1234, 0, 0};
        tbl[8]  = '{1, 0, 5'd0, 16'h0000, 0, 5'd0, 1, 16'h1234, 0, 0};
        tbl[9]  = '{1, 0, 5'd0, 16'h0000, 0, 5'd1, 0, 16'h0000, 0, 0};
        tbl[10] = '{1, 1, 5'd1, 16'hBEEF, 0, 5'd1, 0, 16'h0000, 0, 0};
        tbl[11] = '{1, 0, 5'd0, 16'h0000, 0, 5'd1, 1, 16'h0000, 0, 0};

        cyc();
        chk("reset_outputs", {row_idx, row_on, col_data, frame_done, swap_ack}, '0);
        #2 rst = 1'b0;
        cyc();
        mon = 1'b1;
        chk("idle_outputs", {row_idx, row_on, col_data, frame_done, swap_ack}, '0);

        for (int i = 0; i < 12; i++) begin
            en = tbl[i].en; wr_en = tbl[i].wr; wr_addr = tbl[i].addr;
            wr_data = tbl[i].data; swap_req = tbl[i].swap;
            cyc();
            chk($sformatf("vec%0d", i),
                {row_idx, row_on, col_data, frame_done, swap_ack},
                {tbl[i].row, tbl[i].on, tbl[i].col, tbl[i].fd, tbl[i].ack});
        end
        wr_en = 0; swap_req = 0;

        // Frame period from a fresh start
        do_reset();
        en = 1;
        cyc();
        n = 0;
        while (!frame_done && n < 300) begin cyc(); n++; end
        chk("frame_period", n, FRAME);
        chk("wrap_row", {row_idx, row_on, swap_ack}, {5'd0, 1'b0, 1'b0});
        cyc();
        chk("frame_done_pulse", frame_done, 0);

        // Double buffer: write back bank and request swap during row 10
        n = 0;
        while (row_idx != 5'd10 && n < 300) begin cyc(); n++; end
        chk("wait_row10", n < 300, 1);
        wr_en = 1; wr_addr = 5; wr_data = 16'hA5A5; swap_req = 1;
        cyc();
        wr_addr = 7; wr_data = 16'h7777; swap_req = 0;
        cyc();
        wr_en = 0;
        acks = 0;
        n = 0;
        while (!frame_done && n < 300) begin acks += swap_ack; cyc(); n++; end
        chk("no_early_ack", acks, 0);
        chk("ack_with_frame_done", {frame_done, swap_ack}, 2'b11);
        n = 0;
        while (!(row_idx == 5'd5 && row_on) && n < 300) begin cyc(); n++; end
        chk("row5_new_front", col_data, 16'hA5A5);

        // Disable during the 2nd ON cycle of row 7
        n = 0;
        while (!(row_idx == 5'd7 && row_on) && n < 300) begin cyc(); n++; end
        chk("row7_col", col_data, 16'h7777);
        cyc();
        chk("row7_on2", {row_idx, row_on}, {5'd7, 1'b1});
        en = 0;
        cyc();
        chk("disable_outputs", {row_idx, row_on, col_data, frame_done}, '0);
        en = 1;
        cyc();
        chk("restart_blank", {row_idx, row_on}, {5'd0, 1'b0});
        cyc(); cyc();
        chk("restart_on", {row_idx, row_on}, {5'd0, 1'b1});

        // Async reset while lit with a swap pending
        swap_req = 1;
        cyc();
        swap_req = 0;
        n = 0;
        while (!row_on && n < 20) begin cyc(); n++; end
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {row_idx, row_on, col_data, frame_done, swap_ack}, '0);
        cyc();
        #2 rst = 1'b0;
        en = 0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin cyc(); acks += swap_ack; end
        chk("no_ack_after_reset", acks, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 59) != 0);
            wr_en = $urandom_range(0, 1);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = 16'($urandom);
            swap_req = ($urandom_range(0, 29) == 0);
            cyc();
        end

        mon = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
